// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: request/status bundle between a crossroad controller
// (master) and the turn sequencer (slave). Clock and reset are carried
// separately as plain ports on the sequencer.
interface turn_sequencer_if;
  logic       tick_ms;
  logic       req;
  logic [1:0] dir;
  logic       abort;
  logic       busy;
  logic       done;
  logic [1:0] phase;
  logic [3:0] moving_state;
  logic       turn_left_light;
  logic       turn_right_light;

  modport master (
    output tick_ms, req, dir, abort,
    input  busy, done, phase, moving_state, turn_left_light, turn_right_light
  );

  modport slave (
    input  tick_ms, req, dir, abort,
    output busy, done, phase, moving_state, turn_left_light, turn_right_light
  );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: timed executor for crossroad turn manoeuvres.
// IDLE -> TURN (LIMIT ms ticks) -> COOL (COOL_MS forward ticks) -> DONE (1 cycle) -> IDLE.
// abort returns to IDLE from any phase without a done pulse.
// Optional feature macro: TURN_BLINK_EN -- when defined the active indicator
// blinks with a BLINK_MS half-period during TURN; otherwise it is steady.
module turn_sequencer #(
  parameter int unsigned TURN_MS  = 900,
  parameter int unsigned UTURN_MS = 1800,
  parameter int unsigned COOL_MS  = 600,
  parameter int unsigned BLINK_MS = 250,
  parameter int unsigned CNT_W    = 11
) (
  input  logic             sys_clk,
  input  logic             rst,
  turn_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_TURN = 2'b01,
    S_COOL = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [3:0] MS_STOP  = 4'b0000;
  localparam logic [3:0] MS_FWD   = 4'b0001;
  localparam logic [3:0] MS_LEFT  = 4'b0100;
  localparam logic [3:0] MS_RIGHT = 4'b1000;

  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UTURN = 2'b11;

  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'(TURN_MS - 1);
  localparam logic [CNT_W-1:0] UTURN_LAST = CNT_W'(UTURN_MS - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'((COOL_MS == 0) ? 0 : COOL_MS - 1);

  localparam int unsigned MAX_A   = (TURN_MS > UTURN_MS) ? TURN_MS : UTURN_MS;
  localparam int unsigned MAX_B   = (COOL_MS > BLINK_MS) ? COOL_MS : BLINK_MS;
  localparam int unsigned MAX_LIM = (MAX_A > MAX_B) ? MAX_A : MAX_B;

  // Refuse to elaborate if the tick counter cannot reach the largest limit.
  if (((MAX_LIM - 1) >> CNT_W) != 0) begin : g_cnt_w_too_small
    $error("turn_sequencer: CNT_W too small for configured limits");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_dir;
  logic [3:0]       r_moving;
  logic             r_busy;
  logic             r_done;
  logic             r_left;
  logic             r_right;
`ifdef TURN_BLINK_EN
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_MS - 1);
  logic [CNT_W-1:0] r_blink_cnt;
`endif

  logic w_accept;
  logic w_turn_last;

  // Request acceptance and end-of-turn detection for the latched direction.
  always_comb begin
    w_accept    = bus.req && (bus.dir != 2'b00);
    w_turn_last = (r_cnt == ((r_dir == DIR_UTURN) ? UTURN_LAST : TURN_LAST));
  end

  // Phase FSM with all outputs registered alongside the state.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dir    <= '0;
      r_moving <= MS_STOP;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_left   <= 1'b0;
      r_right  <= 1'b0;
`ifdef TURN_BLINK_EN
      r_blink_cnt <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (bus.abort) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_moving <= MS_STOP;
        r_busy   <= 1'b0;
        r_left   <= 1'b0;
        r_right  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_moving <= MS_STOP;
            if (w_accept) begin
              r_state  <= S_TURN;
              r_dir    <= bus.dir;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_moving <= (bus.dir == DIR_LEFT) ? MS_LEFT : MS_RIGHT;
              r_left   <= (bus.dir == DIR_LEFT);
              r_right  <= (bus.dir != DIR_LEFT);
`ifdef TURN_BLINK_EN
              r_blink_cnt <= '0;
`endif
            end
          end

          S_TURN: begin
            if (bus.tick_ms) begin
              if (w_turn_last) begin
                r_cnt    <= '0;
                r_moving <= MS_FWD;
                r_left   <= 1'b0;
                r_right  <= 1'b0;
                if (COOL_MS == 0) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= S_COOL;
                end
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
`ifdef TURN_BLINK_EN
                // Only the indicator matching the latched direction toggles.
                if (r_blink_cnt == BLINK_LAST) begin
                  r_blink_cnt <= '0;
                  r_left      <= r_left  ^ (r_dir == DIR_LEFT);
                  r_right     <= r_right ^ (r_dir != DIR_LEFT);
                end else begin
                  r_blink_cnt <= r_blink_cnt + CNT_W'(1);
                end
`endif
              end
            end
          end

          S_COOL: begin
            if (bus.tick_ms) begin
              if (r_cnt == COOL_LAST) begin
                r_state <= S_DONE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end

          S_DONE: begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_moving <= MS_STOP;
          end

          default: begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_moving <= MS_STOP;
            r_busy   <= 1'b0;
            r_left   <= 1'b0;
            r_right  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.phase            = r_state;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.moving_state     = r_moving;
  assign bus.turn_left_light  = r_left;
  assign bus.turn_right_light = r_right;

endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: table vectors, directed corner sequences and random
// stimulus for two turn_sequencer builds (COOL_MS=3 and COOL_MS=0), each
// compared every cycle against a tick-count reference model.
module tb_turn_sequencer;
  localparam int unsigned TURN_MS  = 4;
  localparam int unsigned UTURN_MS = 8;
  localparam int unsigned COOL_MS  = 3;
  localparam int unsigned BLINK_MS = 2;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  turn_sequencer_if ifa ();
  turn_sequencer_if ifb ();

  turn_sequencer #(.TURN_MS(TURN_MS), .UTURN_MS(UTURN_MS), .COOL_MS(COOL_MS),
                   .BLINK_MS(BLINK_MS), .CNT_W(4))
    dut_a (.sys_clk(sys_clk), .rst(rst), .bus(ifa));

  turn_sequencer #(.TURN_MS(TURN_MS), .UTURN_MS(UTURN_MS), .COOL_MS(0),
                   .BLINK_MS(BLINK_MS), .CNT_W(4))
    dut_b (.sys_clk(sys_clk), .rst(rst), .bus(ifb));

  int n_checks = 0;
  int n_fail   = 0;

  // Model: whether a manoeuvre is active, ms ticks elapsed since accept, latched dir.
  typedef struct {
    bit          active;
    bit          donec;
    int unsigned ticks;
    logic [1:0]  dir;
  } mstate_t;

  typedef struct {
    logic [1:0] ph;
    logic [3:0] ms;
    logic       busy;
    logic       done;
    logic       ll;
    logic       rl;
  } exp_t;

  mstate_t ma, mb;

  function automatic mstate_t mreset();
    mstate_t s;
    s.active = 0; s.donec = 0; s.ticks = 0; s.dir = 2'b00;
    return s;
  endfunction

  function automatic mstate_t mnext(mstate_t s, bit req, logic [1:0] dir, bit abort,
                                    bit tick, int unsigned cool);
    mstate_t n;
    int unsigned lim;
    n = s;
    if (abort) begin
      n.active = 0; n.donec = 0;
    end else if (s.donec) begin
      n.donec = 0;
    end else if (!s.active) begin
      if (req && dir != 2'b00) begin
        n.active = 1; n.ticks = 0; n.dir = dir;
      end
    end else if (tick) begin
      lim = (s.dir == 2'b11) ? UTURN_MS : TURN_MS;
      n.ticks = s.ticks + 1;
      if (n.ticks == lim + cool) begin
        n.active = 0; n.donec = 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t mexp(mstate_t s);
    exp_t e;
    int unsigned lim;
    bit on;
    e.ph = 2'b00; e.ms = 4'b0000; e.busy = 0; e.done = 0; e.ll = 0; e.rl = 0;
    if (s.donec) begin
      e.ph = 2'b11; e.ms = 4'b0001; e.done = 1;
    end else if (s.active) begin
      lim = (s.dir == 2'b11) ? UTURN_MS : TURN_MS;
      e.busy = 1;
      if (s.ticks < lim) begin
        e.ph = 2'b01;
        e.ms = (s.dir == 2'b01) ? 4'b0100 : 4'b1000;
`ifdef TURN_BLINK_EN
        on = ((s.ticks / BLINK_MS) % 2) == 0;
`else
        on = 1;
`endif
        e.ll = on && (s.dir == 2'b01);
        e.rl = on && (s.dir != 2'b01);
      end else begin
        e.ph = 2'b10; e.ms = 4'b0001;
      end
    end
    return e;
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req_v, $time);
    end
  endtask

  task automatic cmp(string tag, exp_t e, logic [1:0] ph, logic [3:0] ms, logic busy,
                     logic done, logic ll, logic rl);
    chk({tag, ".phase"}, {6'b0, ph}, {6'b0, e.ph});
    chk({tag, ".moving"}, {4'b0, ms}, {4'b0, e.ms});
    chk({tag, ".busy"}, {7'b0, busy}, {7'b0, e.busy});
    chk({tag, ".done"}, {7'b0, done}, {7'b0, e.done});
    chk({tag, ".left"}, {7'b0, ll}, {7'b0, e.ll});
    chk({tag, ".right"}, {7'b0, rl}, {7'b0, e.rl});
  endtask

  task automatic cmp_both();
    cmp("A", mexp(ma), ifa.phase, ifa.moving_state, ifa.busy, ifa.done,
        ifa.turn_left_light, ifa.turn_right_light);
    cmp("B", mexp(mb), ifb.phase, ifb.moving_state, ifb.busy, ifb.done,
        ifb.turn_left_light, ifb.turn_right_light);
  endtask

  // One clock: drive at negedge, advance models at posedge, compare 1 time unit later.
  task automatic step(bit req, logic [1:0] dir, bit abort, bit tick);
    @(negedge sys_clk);
    ifa.req = req; ifa.dir = dir; ifa.abort = abort; ifa.tick_ms = tick;
    ifb.req = req; ifb.dir = dir; ifb.abort = abort; ifb.tick_ms = tick;
    @(posedge sys_clk);
    ma = mnext(ma, req, dir, abort, tick, COOL_MS);
    mb = mnext(mb, req, dir, abort, tick, 0);
    #1;
    cmp_both();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0);
  endtask

  typedef struct {
    bit         req;
    logic [1:0] dir;
    bit         abort;
    bit         tick;
    logic [1:0] ph;
    logic [3:0] ms;
    bit         busy;
    bit         done;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned turn_ticks;
    bit          seen;
    bit          saw_done;
    bit          tk;

    // Expected values for the COOL_MS=3 build, one row per clock.
    vecs[0]  = '{0, 2'b00, 0, 0, 2'b00, 4'b0000, 0, 0};
    vecs[1]  = '{1, 2'b00, 0, 1, 2'b00, 4'b0000, 0, 0};
    vecs[2]  = '{1, 2'b01, 0, 1, 2'b01, 4'b0100, 1, 0};
    vecs[3]  = '{0, 2'b00, 0, 0, 2'b01, 4'b0100, 1, 0};
    vecs[4]  = '{0, 2'b00, 0, 1, 2'b01, 4'b0100, 1, 0};
    vecs[5]  = '{0, 2'b00, 0, 0, 2'b01, 4'b0100, 1, 0};
    vecs[6]  = '{0, 2'b00, 0, 1, 2'b01, 4'b0100, 1, 0};
    vecs[7]  = '{1, 2'b11, 0, 1, 2'b01, 4'b0100, 1, 0};
    vecs[8]  = '{0, 2'b00, 0, 1, 2'b10, 4'b0001, 1, 0};
    vecs[9]  = '{0, 2'b00, 0, 1, 2'b10, 4'b0001, 1, 0};
    vecs[10] = '{0, 2'b00, 0, 1, 2'b10, 4'b0001, 1, 0};
    vecs[11] = '{0, 2'b00, 0, 1, 2'b11, 4'b0001, 0, 1};
    vecs[12] = '{1, 2'b01, 0, 0, 2'b00, 4'b0000, 0, 0};
    vecs[13] = '{1, 2'b10, 0, 0, 2'b01, 4'b1000, 1, 0};
    vecs[14] = '{0, 2'b00, 0, 1, 2'b01, 4'b1000, 1, 0};
    vecs[15] = '{0, 2'b00, 1, 1, 2'b00, 4'b0000, 0, 0};
    vecs[16] = '{1, 2'b01, 1, 0, 2'b00, 4'b0000, 0, 0};
    vecs[17] = '{0, 2'b00, 0, 0, 2'b00, 4'b0000, 0, 0};

    ifa.req = 0; ifa.dir = 2'b00; ifa.abort = 0; ifa.tick_ms = 0;
    ifb.req = 0; ifb.dir = 2'b00; ifb.abort = 0; ifb.tick_ms = 0;
    ma = mreset(); mb = mreset();

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    cmp_both();
    @(negedge sys_clk);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].req, vecs[i].dir, vecs[i].abort, vecs[i].tick);
      chk($sformatf("vec%0d.phase", i), {6'b0, ifa.phase}, {6'b0, vecs[i].ph});
      chk($sformatf("vec%0d.moving", i), {4'b0, ifa.moving_state}, {4'b0, vecs[i].ms});
      chk($sformatf("vec%0d.busy", i), {7'b0, ifa.busy}, {7'b0, vecs[i].busy});
      chk($sformatf("vec%0d.done", i), {7'b0, ifa.done}, {7'b0, vecs[i].done});
    end

    // U-turn: count ticks spent in TURN; a LEFT request mid-turn must be ignored
    step(1, 2'b11, 0, 0);
    turn_ticks = 0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      tk = (c % 2) == 1;
      if (ifa.phase == 2'b01 && tk) turn_ticks++;
      if (c == 5) step(1, 2'b01, 0, tk);
      else        step(0, 2'b00, 0, tk);
      if (ifa.phase != 2'b01) seen = 1;
    end
    chk("uturn.reached_cool", {7'b0, seen}, 8'd1);
    chk("uturn.turn_ticks", turn_ticks[7:0], 8'd8);
    chk("uturn.after_phase", {6'b0, ifa.phase}, 8'd2);
    idle(20);
    for (int c = 0; c < 12; c++) step(0, 2'b00, 0, (c % 2) == 1);

    // Abort during COOL after its first tick
    step(1, 2'b01, 0, 0);
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      step(0, 2'b00, 0, (c % 2) == 1);
      if (ifa.phase == 2'b10) seen = 1;
    end
    chk("abort_cool.reached_cool", {7'b0, seen}, 8'd1);
    step(0, 2'b00, 0, 1);
    chk("abort_cool.still_cool", {6'b0, ifa.phase}, 8'd2);
    step(0, 2'b00, 1, 0);
    chk("abort_cool.phase", {6'b0, ifa.phase}, 8'd0);
    chk("abort_cool.moving", {4'b0, ifa.moving_state}, 8'd0);
    saw_done = 0;
    for (int c = 0; c < 12; c++) begin
      step(0, 2'b00, 0, (c % 2) == 1);
      if (ifa.done) saw_done = 1;
    end
    chk("abort_cool.no_done", {7'b0, saw_done}, 8'd0);

    // Abort coincident with the terminal TURN tick
    step(1, 2'b01, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 2'b00, 0, 0);
      step(0, 2'b00, 0, 1);
    end
    chk("abort_term.in_turn", {6'b0, ifa.phase}, 8'd1);
    step(0, 2'b00, 1, 1);
    chk("abort_term.phase_a", {6'b0, ifa.phase}, 8'd0);
    chk("abort_term.done_b", {7'b0, ifb.done}, 8'd0);
    idle(3);

    // COOL_MS=0 build: RIGHT turn goes straight to DONE after the 4th tick
    step(1, 2'b10, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step(0, 2'b00, 0, 0);
      step(0, 2'b00, 0, 1);
    end
    chk("cool0.phase_b", {6'b0, ifb.phase}, 8'd3);
    chk("cool0.done_b", {7'b0, ifb.done}, 8'd1);
    chk("cool0.phase_a", {6'b0, ifa.phase}, 8'd2);
    idle(10);
    for (int c = 0; c < 8; c++) step(0, 2'b00, 0, (c % 2) == 1);

    // Reset asserted mid-manoeuvre takes effect without a clock edge
    step(1, 2'b01, 0, 0);
    step(0, 2'b00, 0, 1);
    @(negedge sys_clk);
    rst = 1'b1;
    ma = mreset(); mb = mreset();
    #1;
    chk("midreset.phase", {6'b0, ifa.phase}, 8'd0);
    chk("midreset.busy", {7'b0, ifa.busy}, 8'd0);
    chk("midreset.left", {7'b0, ifa.turn_left_light}, 8'd0);
    cmp_both();
    @(negedge sys_clk);
    rst = 1'b0;
    idle(2);

    // Randomized stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) == 0, 2'($urandom % 4), ($urandom % 40) == 0,
           (c < 1500) ? ((c % 2) == 1) : (($urandom % 2) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
